// File: rtl/typing_scorer.sv
// Typing-race scorer: builds the typed buffer and correct mask, then computes WPM and accuracy
// with one shared restoring divider. Define BKSP_PENALTY_EN to count backspaces as keystrokes.
module typing_scorer #(
  parameter int unsigned CHAR_W       = 5,
  parameter int unsigned LINE_LEN     = 25,
  parameter int unsigned CLK_HZ       = 100000000,
  parameter int unsigned TIME_LIMIT_S = 60,
  parameter int unsigned DIV_W        = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [LINE_LEN*CHAR_W-1:0]      target_line,
  input  logic                            key_valid,
  input  logic [CHAR_W-1:0]               key_code,
  input  logic                            key_bksp,
  output logic [LINE_LEN*CHAR_W-1:0]      typed,
  output logic [LINE_LEN-1:0]             correct,
  output logic [$clog2(LINE_LEN+1)-1:0]   cursor,
  output logic [7:0]                      wpm,
  output logic [6:0]                      acc,
  output logic                            finish,
  output logic                            busy
);

  localparam int unsigned CUR_W  = $clog2(LINE_LEN + 1);
  localparam int unsigned PRE_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned QW     = DIV_W + 1;  // quotient bits, one per divide cycle
  localparam int unsigned TW     = QW + 1;
  localparam int unsigned PW     = DIV_W + 7;  // wide enough for correct_keys * 100
  localparam int unsigned ITER_W = $clog2(QW);

  localparam logic [DIV_W-1:0]  CNT_MAX    = '1;
  localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(CLK_HZ - 1);
  localparam logic [7:0]        SECS_LIMIT = 8'(TIME_LIMIT_S);
  localparam logic [CUR_W-1:0]  CUR_END    = CUR_W'(LINE_LEN);
  localparam logic [ITER_W-1:0] ITER_LAST  = ITER_W'(QW - 1);

  typedef enum logic [2:0] {StIdle, StRun, StDivWpm, StDivAcc, StDone} state_e;

  state_e                     state_q;
  logic [LINE_LEN*CHAR_W-1:0] target_q;
  logic [DIV_W-1:0]           total_keys, correct_keys, correct_chars;
  logic [7:0]                 secs_q;
  logic [PRE_W-1:0]           presc_q;
  logic [QW-1:0]              rem_q, dvd_q, quo_q;
  logic [DIV_W-1:0]           dvsr_q;
  logic                       ovf_q;
  logic [ITER_W-1:0]          iter_q;
  logic [7:0]                 wpm_res_q;

  logic             in_run, key_wr, key_bs, slot_hit, tick, timeout, term, qbit;
  logic [CUR_W-1:0] cursor_nxt, bs_pos;
  logic [DIV_W-1:0] tk_nxt, ck_nxt, cc_nxt;
  logic [DIV_W+3:0] cc_x12;
  logic [PW-1:0]    wpm_prod, acc_prod;
  logic [TW-1:0]    trial;
  logic [QW-1:0]    rem_nxt, quo_nxt;

  function automatic logic [DIV_W-1:0] sat_inc(input logic [DIV_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    in_run   = (state_q == StRun);
    key_wr   = in_run && key_valid && !key_bksp && (cursor < CUR_END);
    key_bs   = in_run && key_valid && key_bksp && (cursor != '0);
    bs_pos   = cursor - 1'b1;
    slot_hit = (key_code == target_q[cursor*CHAR_W +: CHAR_W]);

    cursor_nxt = cursor;
    if (key_wr) begin
      cursor_nxt = cursor + 1'b1;
    end else if (key_bs) begin
      cursor_nxt = bs_pos;
    end

    tick    = in_run && (presc_q == PRE_LAST);
    timeout = tick && (secs_q == SECS_LIMIT);
    term    = in_run && ((cursor_nxt == CUR_END) || timeout);

    tk_nxt = total_keys;
    ck_nxt = correct_keys;
    cc_nxt = correct_chars;
    if (key_wr) begin
      tk_nxt = sat_inc(total_keys);
      if (slot_hit) begin
        ck_nxt = sat_inc(correct_keys);
        cc_nxt = sat_inc(correct_chars);
      end
    end
    if (key_bs) begin
      if (correct[bs_pos] && (correct_chars != '0)) cc_nxt = correct_chars - 1'b1;
`ifdef BKSP_PENALTY_EN
      tk_nxt = sat_inc(total_keys);
`else
      tk_nxt = total_keys;
`endif
    end

    // The wpm load happens on the terminating edge, so it uses this cycle's count.
    cc_x12   = ({4'b0, cc_nxt} << 3) + ({4'b0, cc_nxt} << 2);
    wpm_prod = PW'(cc_x12);
    acc_prod = ({7'b0, correct_keys} << 6) + ({7'b0, correct_keys} << 5)
             + ({7'b0, correct_keys} << 2);

    trial   = {rem_q, dvd_q[QW-1]};
    qbit    = (trial >= TW'(dvsr_q));
    rem_nxt = qbit ? QW'(trial - TW'(dvsr_q)) : trial[QW-1:0];
    quo_nxt = {quo_q[QW-2:0], qbit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      target_q      <= '0;
      typed         <= '0;
      correct       <= '0;
      cursor        <= '0;
      wpm           <= '0;
      acc           <= '0;
      finish        <= 1'b0;
      busy          <= 1'b0;
      total_keys    <= '0;
      correct_keys  <= '0;
      correct_chars <= '0;
      secs_q        <= '0;
      presc_q       <= '0;
      rem_q         <= '0;
      dvd_q         <= '0;
      quo_q         <= '0;
      dvsr_q        <= '0;
      ovf_q         <= 1'b0;
      iter_q        <= '0;
      wpm_res_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q       <= StRun;
            target_q      <= target_line;
            typed         <= '0;
            correct       <= '0;
            cursor        <= '0;
            total_keys    <= '0;
            correct_keys  <= '0;
            correct_chars <= '0;
            secs_q        <= 8'd1;
            presc_q       <= '0;
            finish        <= 1'b0;
            busy          <= 1'b1;
          end
        end
        StRun: begin
          presc_q <= tick ? '0 : presc_q + 1'b1;
          if (tick && !timeout) secs_q <= secs_q + 1'b1;
          cursor        <= cursor_nxt;
          total_keys    <= tk_nxt;
          correct_keys  <= ck_nxt;
          correct_chars <= cc_nxt;
          if (key_wr) begin
            typed[cursor*CHAR_W +: CHAR_W] <= key_code;
            correct[cursor]                <= slot_hit;
          end
          if (key_bs) begin
            typed[bs_pos*CHAR_W +: CHAR_W] <= '0;
            correct[bs_pos]                <= 1'b0;
          end
          if (term) begin
            // Upper dividend bits seed the remainder; if they already reach the divisor the
            // quotient cannot fit and wpm saturates.
            state_q <= StDivWpm;
            rem_q   <= QW'(wpm_prod[PW-1:QW]);
            dvd_q   <= wpm_prod[QW-1:0];
            dvsr_q  <= DIV_W'(secs_q);
            ovf_q   <= (QW'(wpm_prod[PW-1:QW]) >= QW'(secs_q));
            quo_q   <= '0;
            iter_q  <= '0;
          end
        end
        StDivWpm: begin
          rem_q  <= rem_nxt;
          dvd_q  <= dvd_q << 1;
          quo_q  <= quo_nxt;
          iter_q <= iter_q + 1'b1;
          if (iter_q == ITER_LAST) begin
            wpm_res_q <= (ovf_q || (|quo_nxt[QW-1:8])) ? 8'hFF : quo_nxt[7:0];
            state_q   <= StDivAcc;
            rem_q     <= QW'(acc_prod[PW-1:QW]);
            dvd_q     <= acc_prod[QW-1:0];
            dvsr_q    <= total_keys;
            quo_q     <= '0;
            iter_q    <= '0;
          end
        end
        StDivAcc: begin
          rem_q  <= rem_nxt;
          dvd_q  <= dvd_q << 1;
          quo_q  <= quo_nxt;
          iter_q <= iter_q + 1'b1;
          if (iter_q == ITER_LAST) begin
            state_q <= StDone;
            wpm     <= wpm_res_q;
            acc     <= (total_keys == '0) ? 7'd100 : quo_nxt[6:0];
            finish  <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_typing_scorer.sv
// Randomized scoreboard bench for typing_scorer: a line-level model predicts each run's result,
// and a monitor checks it when finish rises.
module tb_typing_scorer;

  localparam int CW  = 5;
  localparam int LL  = 25;
  localparam int HZ  = 10;
  localparam int TL  = 60;
  localparam int DW  = 16;
  localparam int LAT = 2 * DW + 2;
  localparam int CUW = $clog2(LL + 1);

`ifdef BKSP_PENALTY_EN
  localparam bit PENALTY = 1'b1;
`else
  localparam bit PENALTY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LL*CW-1:0] target_line = '0;
  logic             key_valid = 1'b0;
  logic [CW-1:0]    key_code = '0;
  logic             key_bksp = 1'b0;
  logic [LL*CW-1:0] typed;
  logic [LL-1:0]    correct;
  logic [CUW-1:0]   cursor;
  logic [7:0]       wpm;
  logic [6:0]       acc;
  logic             finish;
  logic             busy;

  typing_scorer #(
    .CHAR_W      (CW),
    .LINE_LEN    (LL),
    .CLK_HZ      (HZ),
    .TIME_LIMIT_S(TL),
    .DIV_W       (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .target_line(target_line),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_bksp   (key_bksp),
    .typed      (typed),
    .correct    (correct),
    .cursor     (cursor),
    .wpm        (wpm),
    .acc        (acc),
    .finish     (finish),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [127:0] act,
                              input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  typedef struct {
    int               done_cyc;
    logic [LL*CW-1:0] typed;
    logic [LL-1:0]    correct;
    int               cursor;
    int               wpm;
    int               acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic fin_prev = 1'b0;

  // Monitor: every rising finish must match the oldest predicted result.
  always @(negedge clk) begin
    if (finish && !fin_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_finish", finish, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("finish_cycle", cyc, mon_e.done_cyc);
        chk("typed", typed, mon_e.typed);
        chk("correct", correct, mon_e.correct);
        chk("cursor", cursor, mon_e.cursor);
        chk("wpm", wpm, mon_e.wpm);
        chk("acc", acc, mon_e.acc);
        chk("busy_at_done", busy, 1'b0);
      end
    end
    fin_prev <= finish;
  end

  int tgt[LL];
  int last_wpm = 0;
  int last_acc = 0;

  task automatic check_all_zero(input string tag);
    chk({tag, "_typed"}, typed, 0);
    chk({tag, "_correct"}, correct, 0);
    chk({tag, "_cursor"}, cursor, 0);
    chk({tag, "_wpm"}, wpm, 0);
    chk({tag, "_acc"}, acc, 0);
    chk({tag, "_finish"}, finish, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // mode 0 clean, 1 error+fix, 2 no input, 3 ten keys then key on timeout cycle,
  // 4 random dense, 5 random sparse. abort pulls reset in the middle of the accuracy divide.
  task automatic do_run(input int mode, input bit abort);
    int   q[$];
    int   total, ck, k, k_term, term_cyc, cc, secs, w, a, pos, c;
    bit   v, b, term;
    exp_t e;
    total = 0; ck = 0; k = 0; k_term = 0; term = 1'b0;
    for (int i = 0; i < LL; i++) begin
      tgt[i] = $urandom_range(1, 31);
      target_line[i*CW +: CW] = CW'(tgt[i]);
    end
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("finish_cleared", finish, 1'b0);
    chk("wpm_held", wpm, last_wpm);
    chk("acc_held", acc, last_acc);
    while (!term) begin
      pos = q.size();
      v = 1'b0; b = 1'b0; c = 0;
      case (mode)
        0: begin v = (k % 2 == 0); c = tgt[pos]; end
        1: begin
          v = 1'b1;
          if (k == 0) c = (tgt[0] == 1) ? 2 : 1;
          else if (k == 1) b = 1'b1;
          else c = tgt[pos];
        end
        2: begin v = (k == 3); b = 1'b1; end
        3: begin v = (k < 10) || (k == TL * HZ - 1); c = tgt[pos]; end
        4: begin
          v = ($urandom % 2) == 0;
          b = ($urandom % 5) == 0;
          c = (($urandom % 4) != 0) ? tgt[pos] : $urandom_range(0, 31);
          start = ($urandom % 16) == 0;
        end
        default: begin
          v = ($urandom % 25) == 0;
          b = ($urandom % 6) == 0;
          c = (($urandom % 3) != 0) ? tgt[pos] : $urandom_range(0, 31);
        end
      endcase
      key_valid = v; key_bksp = b; key_code = CW'(c);
      @(posedge clk); #1;
      key_valid = 1'b0; key_bksp = 1'b0; start = 1'b0;
      if (v && !b && q.size() < LL) begin
        total++;
        if (c == tgt[q.size()]) ck++;
        q.push_back(c);
      end else if (v && b && q.size() > 0) begin
        void'(q.pop_back());
        if (PENALTY) total++;
      end
      term = (q.size() == LL) || (k == TL * HZ - 1);
      k_term = k;
      k++;
    end
    term_cyc = cyc;

    if (abort) begin
      repeat (LAT - 8) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_all_zero("abort");
      last_wpm = 0;
      last_acc = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (LAT) @(posedge clk);
      #1;
      chk("abort_no_finish", finish, 1'b0);
      return;
    end

    cc = 0;
    e.typed = '0;
    e.correct = '0;
    foreach (q[i]) begin
      e.typed[i*CW +: CW] = CW'(q[i]);
      e.correct[i] = (q[i] == tgt[i]);
      if (q[i] == tgt[i]) cc++;
    end
    secs = k_term / HZ + 1;
    w = (cc * 12) / secs;
    if (w > 255) w = 255;
    a = (total == 0) ? 100 : (ck * 100) / total;
    e.done_cyc = term_cyc + LAT;
    e.cursor = q.size();
    e.wpm = w;
    e.acc = a;
    exp_q.push_back(e);
    last_wpm = w;
    last_acc = a;

    for (int i = 0; i < LAT + 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("finish_seen", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("finish_held", finish, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b1; key_code = 5'd7;
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk("idle_key_ignored", cursor, 0);

    do_run(0, 1'b0);
    do_run(1, 1'b0);
    do_run(2, 1'b0);
    do_run(3, 1'b0);
    do_run(4, 1'b1);
    do_run(0, 1'b0);
    for (int r = 0; r < 6; r++) do_run(4 + (r % 2), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/typing_scorer.md
Name: typing_scorer

Overview:
- Parametrised scoring engine for one typing-race line.
- Latches the target line and accepts decoded keystrokes from the keyboard front end. Builds the typed buffer and per-character correct mask for the display.
- At end of run (line complete or time limit) computes WPM and accuracy with one shared sequential divider, then raises finish.
- Sits between the keyboard decoder / dictionary and the VGA / seven-segment result display.

Parameters:
- CHAR_W, 5, bits per character code; code 0 = blank.
- LINE_LEN, 25, characters per line.
- CLK_HZ, 100000000, clk cycles per second tick.
- TIME_LIMIT_S, 60, run timeout in seconds (1..255).
- DIV_W, 16, divider operand width; counters saturate at 2^DIV_W-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run.
- target_line  in  LINE_LEN*CHAR_W  target line; char i at bits [i*CHAR_W +: CHAR_W]; sampled on start.
- key_valid  in  1  one-cycle strobe, one keystroke.
- key_code  in  CHAR_W  character code, valid with key_valid.
- key_bksp  in  1  with key_valid: keystroke is backspace (key_code ignored).
- typed  out  LINE_LEN*CHAR_W  typed buffer, same packing as target_line.
- correct  out  LINE_LEN  bit i = typed char i equals target char i.
- cursor  out  $clog2(LINE_LEN+1)  next write position.
- wpm  out  8  words per minute, saturated at 255.
- acc  out  7  accuracy percent, 0..100.
- finish  out  1  high in DONE.
- busy  out  1  high in RUN, DIV_WPM, DIV_ACC.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- States: IDLE, RUN, DIV_WPM, DIV_ACC, DONE.
- IDLE/DONE + start → RUN:
  - latch target_line; clear typed, correct, cursor and counters.
  - set secs=1 and clear the prescaler.
  - wpm/acc keep their previous values until the new result is written.
- start in RUN, DIV_WPM or DIV_ACC is ignored.
- RUN, key_valid && !key_bksp, cursor<LINE_LEN:
  - typed[cursor]<=key_code; correct[cursor]<=(key_code==target[cursor]); cursor++.
  - total_keys++.
  - on match, correct_keys++ and correct_chars++.
- RUN, key_valid && key_bksp, cursor>0:
  - cursor--; typed and correct at the new cursor cleared.
  - correct_chars-- if that slot was correct.
  - total_keys and correct_keys unchanged.
- Backspace at cursor 0: no effect.
- key_valid outside RUN is ignored.
- Second tick: the prescaler counts CLK_HZ cycles in RUN. At wrap, if secs==TIME_LIMIT_S the run times out; otherwise secs++. Elapsed time is therefore rounded up, minimum 1.
- Termination is evaluated after that cycle's keystroke is applied; a key and a timeout in the same cycle both take effect:
  - cursor reaches LINE_LEN → DIV_WPM;
  - timeout → DIV_WPM.
- DIV_WPM: restoring divide, 1 quotient bit per cycle, DIV_W+1 cycles.
  - wpm = min(255, floor(correct_chars*12 / secs)).
  - product computed at DIV_W+4 bits before division.
- DIV_ACC: same divider, DIV_W+1 cycles.
  - acc = floor(correct_keys*100 / total_keys).
  - acc = 100 if total_keys == 0.
- DONE:
  - entered exactly 2*DIV_W+2 cycles after the terminating cycle.
  - wpm and acc are written on the DONE-entry edge; finish rises on the same edge.
  - finish stays high until start or reset.
- Counter saturation: total_keys, correct_keys and correct_chars saturate rather than wrap.
- rst_n low at any time, including mid-run or mid-division: immediate return to reset values; a partial result is never output.

Optional Feature:
- BKSP_PENALTY_EN defined: each accepted backspace in RUN (cursor>0) also increments total_keys, which lowers accuracy.
- Not defined: backspace never changes total_keys.

Test Plan:
- Setup for all tests: CLK_HZ=10, TIME_LIMIT_S=60, DIV_W=16.
- Clean run: start, 25 keys all matching, last key in 5th second -> cursor=25, correct all 1, finish after 34 cycles, wpm=60, acc=100, busy low.
- Error + fix: one wrong key, backspace, right key, rest correct, done in 3rd second -> total_keys=26, wpm=100, acc=96. With BKSP_PENALTY_EN: total_keys=27, acc=92.
- Timeout: TIME_LIMIT_S=3, 10 correct keys then idle -> finish at end of 3rd second, wpm=40, acc=100, cursor=10.
- No input: start, no keys -> timeout, wpm=0, acc=100. Backspace at cursor 0 leaves cursor=0.
- Same-cycle key and timeout: key_valid on the wrap cycle -> key applied (cursor increments) and finish still follows 34 cycles later.
- Reset mid-division: rst_n low during DIV_ACC -> all outputs 0 at once. A new start after rst_n release runs normally.
